// File: rtl/uart_brg_pkg.sv
// Shared defaults and configuration type for the UART baud-rate generator.
package uart_pack;
   localparam int unsigned DIV_W   = 16;
   localparam int unsigned FRAC_W  = 4;
   localparam int unsigned OVS     = 16;
   localparam int unsigned DEF_DIV = 27;

   typedef struct packed {
      logic [DIV_W-1:0]  div_int;
      logic [FRAC_W-1:0] div_frac;
   } brg_cfg_t;
endpackage

// File: rtl/uart_brg_pre.sv
// Fractional prescaler: spreads div_frac/2^FRAC_W extra clocks over ovs ticks
// by stretching a period by one clock whenever the fractional accumulator carries.
module uart_brg_pre #(
   parameter int unsigned DIV_W  = uart_pack::DIV_W,
   parameter int unsigned FRAC_W = uart_pack::FRAC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              wrap,
   output logic              ovs_tick
);
   logic [DIV_W-1:0]  pre_cnt;
   logic [FRAC_W-1:0] frac_acc;
   logic [FRAC_W:0]   frac_sum;
   logic [DIV_W:0]    period;

   // Period is one bit wider than the divisor so div_int = 2^DIV_W-1 plus carry cannot overflow.
   always_comb begin
      frac_sum = {1'b0, frac_acc} + {1'b0, div_frac};
      period   = {1'b0, div_int} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]};
      wrap     = en && ({1'b0, pre_cnt} == (period - (DIV_W+1)'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pre_cnt  <= '0;
         frac_acc <= '0;
         ovs_tick <= 1'b0;
      end else begin
         ovs_tick <= wrap;
         if (wrap) begin
            pre_cnt  <= '0;
            frac_acc <= frac_sum[FRAC_W-1:0];
         end else if (en) begin
            pre_cnt <= pre_cnt + DIV_W'(1);
         end
      end
   end
endmodule

// File: rtl/uart_brg.sv
// UART baud-rate generator: oversample, bit-boundary and mid-bit ticks with
// glitch-free divisor changes staged until a bit boundary, restart or idle.
module uart_brg
   import uart_pack::*;
#(
   parameter int unsigned DIV_W   = uart_pack::DIV_W,
   parameter int unsigned FRAC_W  = uart_pack::FRAC_W,
   parameter int unsigned OVS     = uart_pack::OVS,
   parameter int unsigned DEF_DIV = uart_pack::DEF_DIV
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              start_i,
   input  logic [DIV_W-1:0]  div_int_i,
   input  logic [FRAC_W-1:0] div_frac_i,
   input  logic              div_load_i,
   output logic              ovs_tick_o,
   output logic              bit_tick_o,
   output logic              mid_tick_o,
   output logic              pend_o,
   output logic              cfg_err_o
);
   localparam int unsigned OVS_W = $clog2(OVS);
   localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
   localparam logic [OVS_W-1:0] MID_LAST = OVS_W'(OVS / 2 - 1);

   typedef struct packed {
      logic [DIV_W-1:0]  div_int;
      logic [FRAC_W-1:0] div_frac;
   } cfg_t;

   cfg_t             act_cfg, pend_cfg, new_cfg;
   logic             pend, bit_tick, mid_tick, cfg_err;
   logic [OVS_W-1:0] ovs_cnt;
   logic             wrap, bit_wrap, load_ok;

   assign new_cfg  = '{div_int: div_int_i, div_frac: div_frac_i};
   assign load_ok  = div_load_i && (div_int_i >= DIV_W'(2));
   assign bit_wrap = wrap && (ovs_cnt == OVS_LAST);

   uart_brg_pre #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_pre (
      .clk      (clk_i),
      .rst      (rst_i),
      .en       (en_i),
      .clr      (start_i),
      .div_int  (act_cfg.div_int),
      .div_frac (act_cfg.div_frac),
      .wrap     (wrap),
      .ovs_tick (ovs_tick_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         act_cfg  <= '{div_int: DIV_W'(DEF_DIV), div_frac: '0};
         pend_cfg <= '0;
         pend     <= 1'b0;
         ovs_cnt  <= '0;
         bit_tick <= 1'b0;
         mid_tick <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= div_load_i && !load_ok;
         if (start_i) begin
            ovs_cnt  <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
            pend     <= 1'b0;
            if (load_ok)
               act_cfg <= new_cfg;
            else if (pend)
               act_cfg <= pend_cfg;
         end else begin
            bit_tick <= bit_wrap;
            mid_tick <= wrap && (ovs_cnt == MID_LAST);
            if (wrap)
               ovs_cnt <= bit_wrap ? '0 : ovs_cnt + OVS_W'(1);
            // Old pending value is applied first; a load on the same edge re-arms pending.
            if (pend && (bit_wrap || !en_i)) begin
               act_cfg <= pend_cfg;
               pend    <= 1'b0;
            end
            if (load_ok) begin
               pend_cfg <= new_cfg;
               pend     <= 1'b1;
            end
         end
      end
   end

   assign bit_tick_o = bit_tick;
   assign mid_tick_o = mid_tick;
   assign pend_o     = pend;
   assign cfg_err_o  = cfg_err;
endmodule

// File: tb/tb_uart_brg.sv
// Directed bench for uart_brg with default parameters (DEF_DIV = 27, OVS = 16).
module tb_uart_brg;
   logic        clk = 1'b0;
   logic        rst, en, start, div_load;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        ovs_tick, bit_tick, mid_tick, pend, cfg_err;
   int          total = 0;
   int          bad = 0;

   uart_brg dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .start_i    (start),
      .div_int_i  (div_int),
      .div_frac_i (div_frac),
      .div_load_i (div_load),
      .ovs_tick_o (ovs_tick),
      .bit_tick_o (bit_tick),
      .mid_tick_o (mid_tick),
      .pend_o     (pend),
      .cfg_err_o  (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ovs(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!ovs_tick && n < 2000);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int g, sum, n, first, midat;
      rst = 1'b1; en = 1'b0; start = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
      step();
      step();
      check("rst_ovs", ovs_tick, 0);
      check("rst_bit", bit_tick, 0);
      check("rst_mid", mid_tick, 0);
      check("rst_pend", pend, 0);
      check("rst_err", cfg_err, 0);
      rst = 1'b0;
      step();
      check("post_rst_ovs", ovs_tick, 0);

      // load 4.0 while idle: pending for one cycle, then applied
      div_int = 16'd4; div_load = 1'b1;
      step();
      div_load = 1'b0;
      check("idle_pend_set", pend, 1);
      step();
      check("idle_pend_apply", pend, 0);

      en = 1'b1;
      for (int c = 1; c <= 130; c++) begin
         step();
         check("div4_ovs", ovs_tick, (c % 4) == 0);
         check("div4_bit", bit_tick, (c % 64) == 0);
         check("div4_mid", mid_tick, (c % 64) == 32);
      end

      // 3.5 with start+load on the same edge
      en = 1'b0; div_int = 16'd3; div_frac = 4'd8; div_load = 1'b1; start = 1'b1;
      step();
      div_load = 1'b0; start = 1'b0;
      check("start_load_pend", pend, 0);
      en = 1'b1;
      wait_ovs(g);
      check("frac_p0", g, 3);
      wait_ovs(g);
      check("frac_p1", g, 4);
      sum = 7;
      for (int i = 2; i < 16; i++) begin
         wait_ovs(g);
         sum += g;
      end
      check("frac_16ticks", sum, 56);
      check("frac_bit", bit_tick, 1);

      // staged divisor change mid-bit
      div_int = 16'd4; div_frac = '0; div_load = 1'b1; start = 1'b1;
      step();
      div_load = 1'b0; start = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         div_load = (c == 21);
         div_int  = 16'd10;
         step();
         div_load = 1'b0;
         if (c == 30) check("stage_pend_mid", pend, 1);
         if (c == 63) begin
            check("stage_pend_63", pend, 1);
            check("stage_bit_63", bit_tick, 0);
         end
         if (c == 64) begin
            check("stage_bit_64", bit_tick, 1);
            check("stage_pend_64", pend, 0);
         end
      end
      wait_ovs(g);
      check("stage_p10_a", g, 10);
      wait_ovs(g);
      check("stage_p10_b", g, 10);

      // rejected divisor
      div_int = 16'd1; div_load = 1'b1;
      step();
      div_load = 1'b0;
      check("bad_err", cfg_err, 1);
      check("bad_pend", pend, 0);
      step();
      check("bad_err_pulse", cfg_err, 0);
      wait_ovs(g);
      wait_ovs(g);
      check("bad_period", g, 10);

      // enable freeze keeps phase
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("freeze_ovs", ovs_tick, 0);
      end
      en = 1'b1;
      wait_ovs(g);
      check("freeze_resume", g, 6);

      // restart at pre_cnt=2, ovs_cnt=9
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 9; i++) wait_ovs(g);
      step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_ovs", ovs_tick, 0);
      check("restart_bit", bit_tick, 0);
      check("restart_mid", mid_tick, 0);
      n = 0; first = 0; midat = 0;
      while (n < 400) begin
         step();
         n++;
         if (ovs_tick && first == 0) first = n;
         if (mid_tick && midat == 0) midat = n;
         if (bit_tick) break;
      end
      check("restart_first_ovs", first, 10);
      check("restart_mid_at", midat, 80);
      check("restart_bit_at", n, 160);

      // reset with pending divisor
      div_int = 16'd4; div_load = 1'b1;
      step();
      div_load = 1'b0;
      check("rst_pend_before", pend, 1);
      rst = 1'b1;
      step();
      check("rst_mid_pend", pend, 0);
      check("rst_mid_ovs", ovs_tick, 0);
      rst = 1'b0;
      wait_ovs(g);
      check("rst_first_ovs", g, 27);
      check("rst_after_pend", pend, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_brg.md
UART_BRG -- requirements
Module: uart_brg

Interface
REQ-001 Param DIV_W, 16, width of integer divisor.
REQ-002 Param FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock).
REQ-003 Param OVS, 16, oversample ticks per bit; even, >=4.
REQ-004 Param DEF_DIV, from uart_pack, integer divisor loaded at reset.
REQ-005 clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset; synchronous and active-high.
REQ-007 en_i  in  1  count enable; low = freeze counters.
REQ-008 start_i  in  1  synchronous restart of bit timing (frame start resync).
REQ-009 div_int_i  in  DIV_W  new integer divisor, clocks per oversample tick.
REQ-010 div_frac_i  in  FRAC_W  new fractional divisor.
REQ-011 div_load_i  in  1  one-cycle strobe: capture div_int_i/div_frac_i.
REQ-012 ovs_tick_o  out  1  oversample tick pulse.
REQ-013 bit_tick_o  out  1  bit-boundary pulse.
REQ-014 mid_tick_o  out  1  mid-bit sample pulse.
REQ-015 pend_o  out  1  new divisor captured, not yet active.
REQ-016 cfg_err_o  out  1  one-cycle pulse: rejected divisor load.

Function
REQ-017 Prescaler period P = div_int_q + c, c = carry-out of frac_acc (FRAC_W bits) += div_frac_q, added on each ovs tick; mean period = div_int + div_frac/2^FRAC_W.
REQ-018 pre_cnt increments per cycle with en_i=1; at pre_cnt==P-1 it wraps to 0 and ovs_tick_o is 1 in the next cycle (registered, one cycle wide).
REQ-019 ovs_cnt (0..OVS-1) advances on each wrap; bit_tick_o accompanies the ovs tick on which ovs_cnt wraps OVS-1->0.
REQ-020 mid_tick_o accompanies the ovs tick on which ovs_cnt goes OVS/2-1->OVS/2.
REQ-021 en_i=0: all counters hold, all tick outputs 0 next cycle; resume without loss of phase.
REQ-022 div_load_i with div_int_i>=2: capture into pending register, pend_o=1 next cycle; a second load before application overwrites pending.
REQ-023 div_load_i with div_int_i<2: ignored, pending untouched, cfg_err_o=1 next cycle.
REQ-024 Pending divisor becomes active on the next bit-boundary wrap, on start_i, or immediately when en_i=0; pend_o clears same edge.
REQ-025 start_i: clear pre_cnt, ovs_cnt, frac_acc; apply pending divisor; all ticks 0 next cycle; independent of en_i.
REQ-026 start_i and valid div_load_i same cycle: loaded values become active directly; pend_o stays 0.
REQ-027 Priority: rst_i > start_i > div_load_i application > normal count.
REQ-028 Counter compares are full DIV_W width; no overflow for any div_int_i <= 2^DIV_W-1.

Reset
REQ-029 rst_i=1 at a rising edge: div_int_q=DEF_DIV, div_frac_q=0, pending cleared, all counters 0.
REQ-030 During and one cycle after reset: ovs_tick_o, bit_tick_o, mid_tick_o, pend_o, cfg_err_o = 0.
REQ-031 Reset mid-bit discards pending divisor and phase; no partial tick emitted.

Structure
REQ-032 uart_pack holds DEF_DIV, default DIV_W/FRAC_W/OVS, and typedef brg_cfg_t {div_int, div_frac}.
REQ-033 Fractional prescaler (pre_cnt, frac_acc, ovs tick) is sub-module uart_brg_pre; ovs/bit/mid logic and divisor staging stay in uart_brg.

Verification
REQ-034 div=4.0, OVS=16, en=1 from cycle 0 -> ovs_tick_o at cycles 4,8,12..; bit_tick_o every 64 cycles; mid_tick_o at 32, 96.
REQ-035 div_int=3, div_frac=8 (FRAC_W=4) -> ovs periods alternate 3,4; 16 ticks in exactly 56 cycles.
REQ-036 div_load 10 at cycle 20 of a 64-cycle bit -> pend_o=1 until bit_tick at 64, then 10-cycle ovs periods.
REQ-037 div_load_i with div_int_i=1 -> cfg_err_o one-cycle pulse, period unchanged, pend_o=0.
REQ-038 start_i at pre_cnt=2, ovs_cnt=9 -> no tick next cycle; next ovs_tick after full P, bit_tick after 16·P.
REQ-039 rst_i asserted mid-bit with pend_o=1 -> after release, div=DEF_DIV, pend_o=0, first ovs_tick after DEF_DIV cycles.
